result_collector: RTL and testbench

Drains finished pixels from the engine array into the frame buffer. Monitors every engine's `service_req`, grants one engine at a time via a one-hot `req_ack`, samples the shared 27-bit tri-state result bus, converts screen (x, y) to a linear frame-buffer address, and writes the 8-bit iteration count with a ready/valid handshake. Sits between the engine array and the frame-buffer RAM. It is the responder side of the engine service-request protocol.

---
 rtl/result_collector.sv | 133 +++++++++++++
 tb/tb_result_collector.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// rtl/result_collector.sv - Round-robin engine result collector and frame-buffer writer
module result_collector #(
    parameter int NUM_ENGINES = 8,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int FB_AW       = 19
) (
    input  logic                   Engine_CLK,
    input  logic                   eRST_n,
    input  logic [NUM_ENGINES-1:0] service_req,
    output logic [NUM_ENGINES-1:0] req_ack,
    input  logic [26:0]            result_bus,
    output logic                   fb_we,
    output logic [FB_AW-1:0]       fb_addr,
    output logic [7:0]             fb_data,
    input  logic                   fb_ready,
    output logic [FB_AW-1:0]       pixel_count,
    output logic                   frame_done,
    output logic                   range_err
);

    localparam int IW           = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int FRAME_PIXELS = H_RES * V_RES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_CHECK,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t                 state;
    logic [IW-1:0]          last;
    logic [9:0]             x_r;
    logic [8:0]             y_r;
    logic [7:0]             it_r;

    logic                   found;
    logic [IW-1:0]          winner;
    logic [IW-1:0]          idx;
    logic [NUM_ENGINES-1:0] winner_onehot;
    logic                   in_range;
    logic                   last_frame_pixel;

    // Round-robin search starting just after the previously granted engine
    always_comb begin
        found         = 1'b0;
        winner        = '0;
        idx           = '0;
        winner_onehot = '0;
        for (int i = 1; i <= NUM_ENGINES; i++) begin
            idx = IW'((int'(last) + i) % NUM_ENGINES);
            if (!found && service_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        winner_onehot[winner] = 1'b1;
    end

    // Coordinate bounds check and end-of-frame detection
    always_comb begin
        in_range         = (int'(x_r) < H_RES) && (int'(y_r) < V_RES);
        last_frame_pixel = (32'(pixel_count) == 32'(FRAME_PIXELS - 1));
    end

    // Grant / capture / write / release sequencer with registered outputs
    always_ff @(posedge Engine_CLK or negedge eRST_n) begin
        if (!eRST_n) begin
            state       <= S_IDLE;
            last        <= IW'(NUM_ENGINES - 1);
            req_ack     <= '0;
            x_r         <= '0;
            y_r         <= '0;
            it_r        <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        req_ack <= winner_onehot;
                        last    <= winner;
                        state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    x_r     <= result_bus[26:17];
                    y_r     <= result_bus[16:8];
                    it_r    <= result_bus[7:0];
                    req_ack <= '0;
                    state   <= S_CHECK;
                end
                S_CHECK: begin
                    if (in_range) begin
                        fb_addr <= FB_AW'(32'(y_r) * 32'(H_RES) + 32'(x_r));
                        fb_data <= it_r;
                        fb_we   <= 1'b1;
                        state   <= S_WRITE;
                    end else begin
                        range_err <= 1'b1;
                        state     <= S_RELEASE;
                    end
                end
                S_WRITE: begin
                    if (fb_ready) begin
                        fb_we <= 1'b0;
                        if (last_frame_pixel) begin
                            pixel_count <= '0;
                            frame_done  <= 1'b1;
                        end else begin
                            pixel_count <= pixel_count + FB_AW'(1);
                        end
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!service_req[last]) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - Self-checking bench for result_collector with engine and frame-buffer models
module tb_result_collector;

    localparam int NE    = 8;
    localparam int HR    = 20;
    localparam int VR    = 6;
    localparam int AW    = 7;
    localparam int TOTAL = HR * VR;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NE-1:0] service_req;
    logic [NE-1:0] req_ack;
    logic [26:0]   result_bus;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          fb_ready;
    logic [AW-1:0] pixel_count;
    logic          frame_done;
    logic          range_err;

    always #5 clk = ~clk;

    result_collector #(
        .NUM_ENGINES(NE),
        .H_RES      (HR),
        .V_RES      (VR),
        .FB_AW      (AW)
    ) dut (
        .Engine_CLK (clk),
        .eRST_n     (rst_n),
        .service_req(service_req),
        .req_ack    (req_ack),
        .result_bus (result_bus),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_ready   (fb_ready),
        .pixel_count(pixel_count),
        .frame_done (frame_done),
        .range_err  (range_err)
    );

    logic [9:0] eng_x  [NE];
    logic [8:0] eng_y  [NE];
    logic [7:0] eng_it [NE];

    // Shared result bus: the granted engine drives its pixel
    always_comb begin
        result_bus = '0;
        for (int i = 0; i < NE; i++)
            if (req_ack[i]) result_bus = {eng_x[i], eng_y[i], eng_it[i]};
    end

    int   checks = 0;
    int   failures = 0;
    int   last_m, pc_m, chk_cnt, exp_addr, exp_data, stall_run, wraps, dut_fd, grants;
    logic re_m, chk_in, pix_pending, fd_exp, auto_rearm, rand_ready, rand_data;
    int   rearm [NE];
    int   grant_log [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NE-1:0] r, input int last);
        for (int d = 1; d <= NE; d++)
            if (r[(last + d) % NE]) return (last + d) % NE;
        return -1;
    endfunction

    function automatic logic busy();
        logic b = (service_req != 0) || pix_pending || (chk_cnt != 0) || fb_we;
        for (int i = 0; i < NE; i++) if (rearm[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        last_m = NE - 1; pc_m = 0; re_m = 1'b0; chk_cnt = 0;
        pix_pending = 1'b0; fd_exp = 1'b0;
        for (int i = 0; i < NE; i++) rearm[i] = 0;
    endtask

    task automatic tick();
        logic [NE-1:0] req_seen, ack_b;
        logic          acc, stall;
        logic [AW-1:0] addr_b;
        logic [7:0]    data_b;
        int            w;
        req_seen = service_req; ack_b = req_ack;
        acc = fb_we && fb_ready; stall = fb_we && !fb_ready;
        addr_b = fb_addr; data_b = fb_data;
        @(posedge clk); #1;
        fd_exp = 1'b0;
        if (acc) begin
            check("write_expected", pix_pending, 1);
            check("write_addr", addr_b, exp_addr);
            check("write_data", data_b, exp_data);
            pix_pending = 1'b0;
            if (pc_m == TOTAL - 1) begin pc_m = 0; fd_exp = 1'b1; wraps++; end
            else pc_m++;
        end
        if (stall) begin
            check("stall_we", fb_we, 1);
            check("stall_addr", fb_addr, addr_b);
            check("stall_data", fb_data, data_b);
        end
        if (chk_cnt > 0) begin
            chk_cnt--;
            if (chk_cnt == 0) begin
                if (chk_in) begin
                    check("we_rise", fb_we, 1);
                    check("addr_issue", fb_addr, exp_addr);
                    check("data_issue", fb_data, exp_data);
                end else begin
                    re_m = 1'b1;
                    check("no_write_oor", fb_we, 0);
                end
            end
        end
        check("pixel_count", pixel_count, pc_m);
        check("frame_done", frame_done, fd_exp);
        check("range_err", range_err, re_m);
        if (frame_done) dut_fd++;
        for (int i = 0; i < NE; i++)
            if (rearm[i] > 0) begin
                rearm[i]--;
                if (rearm[i] == 0) begin
                    if (rand_data) begin
                        eng_x[i]  = 10'($urandom_range(0, HR + 3));
                        eng_y[i]  = 9'($urandom_range(0, VR + 1));
                        eng_it[i] = 8'($urandom);
                    end
                    service_req[i] = 1'b1;
                end
            end
        if (req_ack != 0) begin
            check("ack_onehot", $onehot(req_ack), 1);
            check("ack_one_cycle", ack_b, 0);
            check("ack_while_busy", pix_pending || (chk_cnt != 0), 0);
            w = rr_pick(req_seen, last_m);
            check("ack_winner", req_ack, (w < 0) ? 0 : (1 << w));
            service_req = service_req & ~req_ack;
            if (w >= 0) begin
                last_m = w; grants++; grant_log.push_back(w);
                chk_in  = (eng_x[w] < HR) && (eng_y[w] < VR);
                chk_cnt = 2;
                if (chk_in) begin
                    exp_addr = eng_y[w] * HR + eng_x[w];
                    exp_data = eng_it[w];
                    pix_pending = 1'b1;
                end
                rearm[w] = auto_rearm ? $urandom_range(8, 12) : 0;
            end
        end
        if (rand_ready) begin
            fb_ready  = (stall_run >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            stall_run = fb_ready ? 0 : stall_run + 1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy() && n < budget) begin tick(); n++; end
        check("drain_timeout", n < budget, 1);
        tick(); tick();
    endtask

    task automatic wait_we(input int budget);
        int n = 0;
        while (!fb_we && n < budget) begin tick(); n++; end
        check("wait_we_timeout", fb_we, 1);
    endtask

    task automatic set_eng(input int i, input int x, input int y, input int it);
        eng_x[i] = 10'(x); eng_y[i] = 9'(y); eng_it[i] = 8'(it);
    endtask

    initial begin
        int pc_save, start, n, g0;
        for (int i = 0; i < NE; i++) set_eng(i, i, 0, i);
        model_reset();
        wraps = 0; dut_fd = 0; grants = 0; stall_run = 0;
        auto_rearm = 1'b0; rand_ready = 1'b0; rand_data = 1'b0;
        service_req = '0; fb_ready = 1'b1; rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_req_ack", req_ack, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_pixel_count", pixel_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_range_err", range_err, 0);
        rst_n = 1'b1;

        // single request from engine 2
        set_eng(2, 5, 2, 8'h3C);
        service_req = 8'h04;
        drain(50);
        check("single_count", pixel_count, 1);

        // out-of-range then boundary pixels
        set_eng(3, 700, 1, 8'h11);
        pc_save = pc_m;
        service_req = 8'h08;
        drain(50);
        check("oor_flag", range_err, 1);
        check("oor_count_held", pixel_count, pc_save);
        set_eng(4, HR - 1, VR - 1, 8'hA5);
        set_eng(5, HR, 0, 8'h01);
        set_eng(6, 0, VR, 8'h02);
        service_req = 8'h70;
        drain(100);
        check("boundary_count", pixel_count, pc_save + 1);

        // back-pressure: stall the RAM for 10 cycles with another engine waiting
        set_eng(0, 7, 3, 8'h77);
        set_eng(1, 8, 3, 8'h78);
        fb_ready = 1'b0;
        service_req = 8'h01;
        wait_we(20);
        service_req[1] = 1'b1;
        g0 = grants;
        for (int i = 0; i < 10; i++) tick();
        check("stall_no_grant", grants, g0);
        fb_ready = 1'b1;
        drain(100);

        // fairness with all engines continuously re-requesting
        for (int i = 0; i < NE; i++) set_eng(i, $urandom_range(0, HR - 1), $urandom_range(0, VR - 1), $urandom);
        grant_log.delete();
        start = (last_m + 1) % NE;
        auto_rearm = 1'b1;
        service_req = '1;
        n = 0;
        while (grant_log.size() < 2 * NE && n < 400) begin tick(); n++; end
        check("fair_grants", grant_log.size() >= 2 * NE, 1);
        for (int k = 0; k < 2 * NE && k < grant_log.size(); k++)
            check("fair_order", grant_log[k], (start + k) % NE);
        auto_rearm = 1'b0;
        drain(300);

        // randomized traffic with RAM stalls, continuing through frame wraps
        rand_data = 1'b1; rand_ready = 1'b1; auto_rearm = 1'b1;
        for (int i = 0; i < NE; i++) rearm[i] = $urandom_range(1, 12);
        n = 0;
        while (wraps < 2 && n < 8000) begin tick(); n++; end
        check("wrap_reached", wraps >= 2, 1);
        auto_rearm = 1'b0;
        drain(500);
        rand_ready = 1'b0; rand_data = 1'b0; fb_ready = 1'b1;
        check("frame_done_pulses", dut_fd, wraps);

        // reset while a write is outstanding
        set_eng(6, 3, 1, 8'h66);
        set_eng(5, 4, 4, 8'h55);
        fb_ready = 1'b0;
        service_req = 8'h40;
        wait_we(20);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_fb_we", fb_we, 0);
        check("mid_rst_fb_addr", fb_addr, 0);
        check("mid_rst_fb_data", fb_data, 0);
        check("mid_rst_req_ack", req_ack, 0);
        check("mid_rst_pixel_count", pixel_count, 0);
        check("mid_rst_range_err", range_err, 0);
        model_reset();
        service_req = 8'h60;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        fb_ready = 1'b1;
        g0 = grants;
        n = 0;
        while (grants == g0 && n < 2) begin tick(); n++; end
        check("post_rst_grant", grants > g0, 1);
        drain(100);
        check("post_rst_count", pixel_count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
